// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions: channel opcodes, the buffered response entry
// and helpers that derive byte-lane geometry from the data width.
package tlul_pkg;

    typedef enum logic [2:0] {
        A_PUT_FULL      = 3'd0,
        A_PUT_PARTIAL   = 3'd1,
        A_ARITHMETIC    = 3'd2,
        A_LOGICAL       = 3'd3,
        A_GET           = 3'd4,
        A_INTENT        = 3'd5,
        A_ACQUIRE_BLOCK = 3'd6,
        A_ACQUIRE_PERM  = 3'd7
    } a_op_e;

    typedef enum logic [2:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1,
        D_HINT_ACK        = 3'd2
    } d_op_e;

    // Response entry fields are sized for the widest supported configuration;
    // narrower instances zero-extend into them.
    localparam int RSP_SIZE_W   = 4;
    localparam int RSP_SOURCE_W = 16;
    localparam int RSP_DATA_W   = 64;

    typedef struct packed {
        d_op_e                    opcode;
        logic                     error;
        logic [RSP_SIZE_W-1:0]    size;
        logic [RSP_SOURCE_W-1:0]  source;
        logic [RSP_DATA_W-1:0]    data;
    } rsp_entry_t;

    function automatic int strb_of(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int log2_strb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/tlul_sram_slave_if.sv
// TL-UL A/D channel bundle between one master and one SRAM slave.
interface tlul_sram_slave_if #(
    parameter int TL_ADDR_WIDTH   = 32,
    parameter int TL_DATA_WIDTH   = 32,
    parameter int TL_SOURCE_WIDTH = 3,
    parameter int TL_SINK_WIDTH   = 1,
    parameter int TL_SIZE_WIDTH   = 2
);
    localparam int STRB = TL_DATA_WIDTH / 8;

    logic                       a_valid;
    logic                       a_ready;
    logic [2:0]                 a_opcode;
    logic [2:0]                 a_param;
    logic [TL_SIZE_WIDTH-1:0]   a_size;
    logic [TL_SOURCE_WIDTH-1:0] a_source;
    logic [TL_ADDR_WIDTH-1:0]   a_address;
    logic [STRB-1:0]            a_mask;
    logic [TL_DATA_WIDTH-1:0]   a_data;

    logic                       d_valid;
    logic                       d_ready;
    logic [2:0]                 d_opcode;
    logic [2:0]                 d_param;
    logic [TL_SIZE_WIDTH-1:0]   d_size;
    logic [TL_SINK_WIDTH-1:0]   d_sink;
    logic [TL_SOURCE_WIDTH-1:0] d_source;
    logic [TL_DATA_WIDTH-1:0]   d_data;
    logic                       d_error;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output d_ready,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_sink, d_source, d_data, d_error
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  d_ready,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_sink, d_source, d_data, d_error
    );

endinterface

// File: rtl/tlul_rsp_fifo.sv
// Circular response buffer; push and pop may happen on the same edge,
// including while full.
module tlul_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = store[rd_ptr];

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlul_sram_slave.sv
// TL-UL single-beat SRAM slave: A-channel decode with error screening,
// byte-enable RAM, one pipeline stage, then an in-order response buffer.
module tlul_sram_slave
    import tlul_pkg::*;
#(
    parameter int                       TL_ADDR_WIDTH   = 32,
    parameter int                       TL_DATA_WIDTH   = 32,
    parameter int                       TL_SOURCE_WIDTH = 3,
    parameter int                       TL_SINK_WIDTH   = 1,
    parameter int                       TL_SIZE_WIDTH   = 2,
    parameter logic [TL_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                       MEM_DEPTH       = 256,
    parameter int                       RSP_DEPTH       = 4,
    parameter logic [TL_SINK_WIDTH-1:0] SINK_ID         = '0
) (
    input  logic clk,
    input  logic reset,
    tlul_sram_slave_if.slave bus
);
    localparam int STRB      = strb_of(TL_DATA_WIDTH);
    localparam int LOG2_STRB = log2_strb(TL_DATA_WIDTH);
    localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam logic [TL_ADDR_WIDTH:0] MEM_BYTES = (TL_ADDR_WIDTH + 1)'(MEM_DEPTH * STRB);

    logic [TL_DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [TL_DATA_WIDTH-1:0]   rd_data;

    logic [TL_ADDR_WIDTH-1:0]   offset;
    logic [TL_ADDR_WIDTH-1:0]   align_mask;
    logic                       addr_ok;
    logic                       size_ok;
    logic                       align_ok;
    logic                       addr_err;
    logic                       a_fire;
    logic [IDX_W-1:0]           word_idx;
    logic [STRB-1:0]            lane_we;
    logic                       mem_rd;
    d_op_e                      rsp_op;
    logic                       rsp_err;

    logic                       s1_valid;
    d_op_e                      s1_op;
    logic                       s1_err;
    logic                       s1_has_data;
    logic [TL_SIZE_WIDTH-1:0]   s1_size;
    logic [TL_SOURCE_WIDTH-1:0] s1_source;

    rsp_entry_t                 push_entry;
    rsp_entry_t                 rsp_head;
    logic [CNT_W-1:0]           rsp_count;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       d_valid;
    logic                       d_pop;
    logic                       unused_bits;

    // Backpressure looks only at registered occupancy so a_ready never
    // depends on a_valid or d_ready in the same cycle.
    assign bus.a_ready = !reset && ((int'(rsp_count) + int'(s1_valid)) < RSP_DEPTH);
    assign a_fire      = bus.a_valid && bus.a_ready;

    assign offset     = bus.a_address - BASE_ADDR;
    assign addr_ok    = (bus.a_address >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
    assign size_ok    = int'(bus.a_size) <= LOG2_STRB;
    assign align_mask = ~({TL_ADDR_WIDTH{1'b1}} << bus.a_size);
    assign align_ok   = (bus.a_address & align_mask) == '0;
    assign addr_err   = !(addr_ok && size_ok && align_ok);
    assign word_idx   = offset[LOG2_STRB +: IDX_W];

    // Opcode decode: response opcode, error flag and memory side effects.
    always_comb begin
        rsp_op  = D_ACCESS_ACK;
        rsp_err = addr_err;
        lane_we = '0;
        mem_rd  = 1'b0;
        case (a_op_e'(bus.a_opcode))
            A_PUT_FULL:    lane_we = addr_err ? '0 : '1;
            A_PUT_PARTIAL: lane_we = addr_err ? '0 : bus.a_mask;
            A_GET: begin
                rsp_op = D_ACCESS_ACK_DATA;
                mem_rd = !addr_err;
            end
            A_INTENT:      rsp_op = D_HINT_ACK;
            default:       rsp_err = 1'b1;
        endcase
    end

    // Single-port byte-enable RAM: lane writes for Puts, registered read for Gets.
    always_ff @(posedge clk) begin
        if (a_fire) begin
            for (int i = 0; i < STRB; i++) begin
                if (lane_we[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.a_data[8*i +: 8];
                end
            end
            if (mem_rd) begin
                rd_data <= mem[word_idx];
            end
        end
    end

    // Stage s1: hold the accepted request's response attributes for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_op       <= D_ACCESS_ACK;
            s1_err      <= 1'b0;
            s1_has_data <= 1'b0;
            s1_size     <= '0;
            s1_source   <= '0;
        end else begin
            s1_valid <= a_fire;
            if (a_fire) begin
                s1_op       <= rsp_op;
                s1_err      <= rsp_err;
                s1_has_data <= mem_rd;
                s1_size     <= bus.a_size;
                s1_source   <= bus.a_source;
            end
        end
    end

    // Assemble the response entry; failed or dataless requests carry zero data.
    always_comb begin
        push_entry        = '0;
        push_entry.opcode = s1_op;
        push_entry.error  = s1_err;
        push_entry.size   = RSP_SIZE_W'(s1_size);
        push_entry.source = RSP_SOURCE_W'(s1_source);
        push_entry.data   = s1_has_data ? RSP_DATA_W'(rd_data) : '0;
    end

    tlul_rsp_fifo #(
        .WIDTH ($bits(rsp_entry_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s1_valid),
        .push_data (push_entry),
        .pop       (d_pop),
        .head      (rsp_head),
        .count     (rsp_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign d_valid      = !reset && !fifo_empty;
    assign d_pop        = d_valid && bus.d_ready;

    assign bus.d_valid  = d_valid;
    assign bus.d_opcode = d_valid ? rsp_head.opcode : D_ACCESS_ACK;
    assign bus.d_param  = '0;
    assign bus.d_size   = d_valid ? rsp_head.size[TL_SIZE_WIDTH-1:0] : '0;
    assign bus.d_sink   = SINK_ID;
    assign bus.d_source = d_valid ? rsp_head.source[TL_SOURCE_WIDTH-1:0] : '0;
    assign bus.d_data   = d_valid ? rsp_head.data[TL_DATA_WIDTH-1:0] : '0;
    assign bus.d_error  = d_valid && rsp_head.error;

    // a_param carries no meaning for this slave; entry padding bits are never read.
    assign unused_bits = ^{bus.a_param, rsp_head, offset, fifo_full};

endmodule

// File: tb/tb_tlul_sram_slave.sv
// Randomized and directed bench for tlul_sram_slave against a
// transaction-level memory/response model.
module tb_tlul_sram_slave;
    import tlul_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tlul_sram_slave_if bus();

    tlul_sram_slave dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic        err;
        logic [2:0]  src;
        logic [1:0]  size;
        logic [31:0] data;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [256];
    logic [31:0] last_data = '0;
    logic        last_err  = 1'b0;
    logic [2:0]  last_op   = '0;
    logic [2:0]  last_src  = '0;
    bit          rand_dready = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one accepted request: update memory, queue the response.
    function automatic void model_accept(input logic [2:0] op, input logic [31:0] addr,
                                         input logic [1:0] size, input logic [3:0] mask,
                                         input logic [31:0] data, input logic [2:0] src);
        exp_t        e;
        int unsigned nbytes = 1 << size;
        bit          bad    = (addr >= 32'd1024) || (size > 2'd2) || ((addr % nbytes) != 0);
        int          w      = int'(addr / 4) % 256;
        e.op   = 3'd0;
        e.err  = bad;
        e.src  = src;
        e.size = size;
        e.data = '0;
        case (op)
            3'd0: if (!bad) ref_mem[w] = data;
            3'd1: if (!bad) for (int i = 0; i < 4; i++) if (mask[i]) ref_mem[w][8*i +: 8] = data[8*i +: 8];
            3'd4: begin e.op = 3'd1; if (!bad) e.data = ref_mem[w]; end
            3'd5: e.op = 3'd2;
            default: e.err = 1'b1;
        endcase
        exp_q.push_back(e);
    endfunction

    // Present one request (called at posedge+1) and hold it until accepted.
    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                        input logic [3:0] mask, input logic [31:0] data, input logic [2:0] src);
        bit ok = 1'b0;
        bus.a_valid   = 1'b1;
        bus.a_opcode  = op;
        bus.a_param   = 3'($urandom_range(0, 7));
        bus.a_size    = size;
        bus.a_source  = src;
        bus.a_address = addr;
        bus.a_mask    = mask;
        bus.a_data    = data;
        for (int t = 0; t < 64 && !ok; t++) begin
            if (rand_dready) bus.d_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.a_ready) begin
                model_accept(op, addr, size, mask, data, src);
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("a_accept", 64'(ok), 64'd1);
    endtask

    task automatic idle();
        bus.a_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Response scoreboard: every D handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && bus.d_valid && bus.d_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("d_opcode", 64'(bus.d_opcode), 64'(mon_e.op));
                chk("d_error",  64'(bus.d_error),  64'(mon_e.err));
                chk("d_source", 64'(bus.d_source), 64'(mon_e.src));
                chk("d_size",   64'(bus.d_size),   64'(mon_e.size));
                chk("d_param",  64'(bus.d_param),  64'd0);
                chk("d_sink",   64'(bus.d_sink),   64'd0);
                if (mon_e.op == 3'd1) chk("d_data", 64'(bus.d_data), 64'(mon_e.data));
                last_data = bus.d_data;
                last_err  = bus.d_error;
                last_op   = bus.d_opcode;
                last_src  = bus.d_source;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.a_valid   = 1'b0;
        bus.a_opcode  = '0;
        bus.a_param   = '0;
        bus.a_size    = '0;
        bus.a_source  = '0;
        bus.a_address = '0;
        bus.a_mask    = '0;
        bus.a_data    = '0;
        bus.d_ready   = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", 64'(bus.a_ready), 64'd0);
        chk("rst_d_valid", 64'(bus.d_valid), 64'd0);
        chk("rst_d_data",  64'(bus.d_data),  64'd0);
        chk("rst_d_op",    64'(bus.d_opcode), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("a_ready_after_rst", 64'(bus.a_ready), 64'd1);
        @(posedge clk); #1;

        // Give every word a known value
        for (int w = 0; w < 256; w++) send(3'd0, 32'(w * 4), 2'd2, 4'hF, $urandom, 3'(w));
        idle();
        wait_drain();

        // PutFull then Get, with two-cycle response latency
        send(3'd0, 32'h10, 2'd2, 4'hF, 32'hDEADBEEF, 3'd3);
        idle();
        @(negedge clk);
        chk("lat_s1", 64'(bus.d_valid), 64'd0);
        @(negedge clk);
        chk("lat_d", 64'(bus.d_valid), 64'd1);
        @(posedge clk); #1;
        wait_drain();
        chk("put_ack_op", 64'(last_op), 64'd0);
        chk("put_ack_err", 64'(last_err), 64'd0);
        send(3'd4, 32'h10, 2'd2, 4'h0, 32'h0, 3'd5);
        idle();
        wait_drain();
        chk("get_data", 64'(last_data), 64'hDEADBEEF);
        chk("get_src", 64'(last_src), 64'd5);

        // PutPartial immediately followed by Get of the same word
        send(3'd1, 32'h10, 2'd2, 4'b0101, 32'h11223344, 3'd1);
        send(3'd4, 32'h10, 2'd2, 4'h0, 32'h0, 3'd2);
        idle();
        wait_drain();
        chk("partial_get", 64'(last_data), 64'hDE22BE44);

        // Address errors
        send(3'd4, 32'h400, 2'd2, 4'h0, 32'h0, 3'd6);
        idle();
        wait_drain();
        chk("oor_err", 64'(last_err), 64'd1);
        chk("oor_op", 64'(last_op), 64'd1);
        chk("oor_data", 64'(last_data), 64'd0);
        send(3'd4, 32'h2, 2'd2, 4'h0, 32'h0, 3'd7);
        idle();
        wait_drain();
        chk("misalign_err", 64'(last_err), 64'd1);

        // Unsupported opcode, empty-mask partial, Intent
        send(3'd2, 32'h10, 2'd2, 4'hF, 32'hFFFFFFFF, 3'd0);
        idle();
        wait_drain();
        chk("arith_op", 64'(last_op), 64'd0);
        chk("arith_err", 64'(last_err), 64'd1);
        send(3'd1, 32'h10, 2'd2, 4'h0, 32'hFFFFFFFF, 3'd1);
        send(3'd4, 32'h10, 2'd2, 4'h0, 32'h0, 3'd2);
        idle();
        wait_drain();
        chk("mem_unchanged", 64'(last_data), 64'hDE22BE44);
        send(3'd5, 32'h20, 2'd2, 4'h0, 32'h0, 3'd4);
        idle();
        wait_drain();
        chk("intent_op", 64'(last_op), 64'd2);
        chk("intent_err", 64'(last_err), 64'd0);

        // Backpressure: five Gets against a stalled D channel
        bus.d_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(3'd4, 32'(i * 4), 2'd2, 4'h0, 32'h0, 3'(i));
                idle();
            end
            begin
                for (int t = 0; t < 40 && exp_q.size() < 4; t++) @(negedge clk);
                chk("stall_accepted", 64'(exp_q.size()), 64'd4);
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_a_ready", 64'(bus.a_ready), 64'd0);
                    chk("stall_d_valid", 64'(bus.d_valid), 64'd1);
                    chk("stall_d_data", 64'(bus.d_data), 64'(exp_q[0].data));
                    chk("stall_d_source", 64'(bus.d_source), 64'(exp_q[0].src));
                end
                @(posedge clk); #1;
                bus.d_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset with three responses buffered
        bus.d_ready = 1'b0;
        send(3'd4, 32'h10, 2'd2, 4'h0, 32'h0, 3'd1);
        send(3'd4, 32'h14, 2'd2, 4'h0, 32'h0, 3'd2);
        send(3'd4, 32'h18, 2'd2, 4'h0, 32'h0, 3'd3);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_d_valid", 64'(bus.d_valid), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_d_valid", 64'(bus.d_valid), 64'd0);
        chk("mid_rst_a_ready", 64'(bus.a_ready), 64'd0);
        chk("mid_rst_d_data", 64'(bus.d_data), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_a_ready", 64'(bus.a_ready), 64'd1);
        chk("post_rst_d_valid", 64'(bus.d_valid), 64'd0);
        @(posedge clk); #1;
        bus.d_ready = 1'b1;
        send(3'd4, 32'h10, 2'd2, 4'h0, 32'h0, 3'd4);
        idle();
        wait_drain();
        chk("post_rst_mem", 64'(last_data), 64'hDE22BE44);

        // Randomized traffic with random D-channel backpressure
        rand_dready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  op;
            logic [1:0]  size;
            logic [31:0] addr;
            case ($urandom_range(0, 9))
                0, 1:    op = 3'd0;
                2, 3:    op = 3'd1;
                4, 5, 6: op = 3'd4;
                7:       op = 3'd5;
                default: op = 3'($urandom_range(0, 7));
            endcase
            size = 2'($urandom_range(0, 3));
            addr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 2047))
                                               : 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << size) - 32'd1);
            send(op, addr, size, 4'($urandom_range(0, 15)), $urandom, 3'($urandom_range(0, 7)));
        end
        idle();
        rand_dready = 1'b0;
        bus.d_ready = 1'b1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
